msrv32_pipe_ctrl: RTL

MSRV32_PIPE_CTRL -- requirements
Module: msrv32_pipe_ctrl

---
 rtl/msrv32_pipe_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline hazard/redirect controller for the three-stage msrv32 core.
// Optional stall-cycle counter is built when MSRV32_STALL_CNT_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal issue; resolves trap, mem wait, branch, load-use
// FLUSH    | redirect in progress; bubbles into stage-1/stage-2 registers
// MEM_WAIT | data memory busy; whole front end held
// LD_STALL | one-cycle gap after a load-use bubble; no action taken
module msrv32_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 32
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       trap_taken_in,
    input  logic       branch_taken_in,
    input  logic       dmem_wait_in,
    input  logic       ex_load_in,
    input  logic [4:0] ex_rd_addr_in,
    input  logic [4:0] id_rs1_addr_in,
    input  logic [4:0] id_rs2_addr_in,
    output logic       stall_pc_out,
    output logic       stall_reg1_out,
    output logic       stall_reg2_out,
    output logic       flush_reg1_out,
    output logic       flush_reg2_out,
    output logic [1:0] state_out
`ifdef MSRV32_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_out
`endif
);

    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] FLUSH    = 2'b01;
    localparam logic [1:0] MEM_WAIT = 2'b10;
    localparam logic [1:0] LD_STALL = 2'b11;

    // The redirect cycle itself is the first flush cycle, so the counter covers the rest.
    localparam logic [2:0] FLUSH_LOAD     = 3'(FLUSH_CYCLES - 1);
    localparam logic [1:0] REDIRECT_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || STALL_CNT_W < 1) begin : g_param_check
        $error("msrv32_pipe_ctrl: FLUSH_CYCLES must be 1..7 and STALL_CNT_W >= 1");
    end

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] flush_cnt_q;
    logic [2:0] flush_cnt_d;
    logic       hazard;
    logic       redirect;

    assign hazard = ex_load_in && (ex_rd_addr_in != 5'd0) &&
                    ((ex_rd_addr_in == id_rs1_addr_in) || (ex_rd_addr_in == id_rs2_addr_in));

    // Trap wins in every state; a branch only redirects from RUN and loses to a memory wait.
    assign redirect = trap_taken_in ||
                      ((state_q == RUN) && branch_taken_in && !dmem_wait_in);

    assign state_out = state_q;

    always_comb begin
        stall_pc_out   = 1'b0;
        stall_reg1_out = 1'b0;
        stall_reg2_out = 1'b0;
        flush_reg1_out = 1'b0;
        flush_reg2_out = 1'b0;
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;

        if (redirect) begin
            flush_reg1_out = 1'b1;
            flush_reg2_out = 1'b1;
            flush_cnt_d    = FLUSH_LOAD;
            state_d        = REDIRECT_STATE;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmem_wait_in) begin
                        stall_pc_out   = 1'b1;
                        stall_reg1_out = 1'b1;
                        stall_reg2_out = 1'b1;
                        state_d        = MEM_WAIT;
                    end else if (hazard) begin
                        stall_pc_out   = 1'b1;
                        stall_reg1_out = 1'b1;
                        flush_reg2_out = 1'b1;
                        state_d        = LD_STALL;
                    end
                end
                FLUSH: begin
                    flush_reg1_out = 1'b1;
                    flush_reg2_out = 1'b1;
                    if (flush_cnt_q != 3'd0) begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                    if (flush_cnt_q <= 3'd1) begin
                        state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_wait_in) begin
                        stall_pc_out   = 1'b1;
                        stall_reg1_out = 1'b1;
                        stall_reg2_out = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                LD_STALL: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        if (reset_in) begin
            stall_pc_out   = 1'b0;
            stall_reg1_out = 1'b0;
            stall_reg2_out = 1'b0;
            flush_reg1_out = 1'b0;
            flush_reg2_out = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef MSRV32_STALL_CNT_EN
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            stall_cnt_out <= '0;
        end else if (stall_pc_out && !(&stall_cnt_out)) begin
            stall_cnt_out <= stall_cnt_out + STALL_CNT_W'(1);
        end
    end
`endif

endmodule
